// File: rtl/sort_16x8b_bitonic_seq_pkg.sv
// Shared types and the bitonic (k,j) stage schedule for the sequenced sorter.
// The schedule functions take the batch size so the top can be resized.
package sort_bitonic_pkg;

   localparam int N_DEF = 16;
   localparam int LOG2N = $clog2(N_DEF);
   localparam int NSTG  = LOG2N * (LOG2N + 1) / 2;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Stages run k = 2,4,..,n and, inside each k, j = k/2 down to 1.
   function automatic int stage_k(input int stg, input int n);
      int s;
      int res;
      s   = 0;
      res = 0;
      for (int k = 2; k <= 64; k = k * 2) begin
         for (int j = k / 2; j >= 1; j = j / 2) begin
            if (k <= n) begin
               if (s == stg) res = k;
               s = s + 1;
            end
         end
      end
      return res;
   endfunction

   function automatic int stage_j(input int stg, input int n);
      int s;
      int res;
      s   = 0;
      res = 0;
      for (int k = 2; k <= 64; k = k * 2) begin
         for (int j = k / 2; j >= 1; j = j / 2) begin
            if (k <= n) begin
               if (s == stg) res = j;
               s = s + 1;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sort_16x8b_bitonic_seq_cmp_exch.sv
// Unsigned compare-exchange: up=1 puts the minimum on lo_pos, up=0 the maximum.
// Equal inputs pass straight through.
module cmp_exch
   import sort_bitonic_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         up,
   output logic [W-1:0] lo_pos,
   output logic [W-1:0] hi_pos
);

   logic a_gt;

   assign a_gt   = (a > b);
   assign lo_pos = up ? (a_gt ? b : a) : (a_gt ? a : b);
   assign hi_pos = up ? (a_gt ? a : b) : (a_gt ? b : a);

endmodule

// File: rtl/sort_16x8b_bitonic_seq.sv
// Sequenced bitonic sorter: load N elements, run one network stage per clock
// through N/2 shared compare-exchange units, then stream the result ascending.
module sort_16x8b_bitonic_seq
   import sort_bitonic_pkg::*;
#(
   parameter int W = 8,
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         abort,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam int LOG2N_T = $clog2(N);
   localparam int NSTG_T  = LOG2N_T * (LOG2N_T + 1) / 2;
   localparam int IW      = LOG2N_T;
   localparam int SW      = $clog2(NSTG_T + 1);
   localparam int NU      = N / 2;

   state_t          state_q, state_nxt;
   logic [IW-1:0]   idx_q, idx_nxt;
   logic [SW-1:0]   stg_q, stg_nxt;
   logic            load_en, sort_en;

   logic [W-1:0]    bank [N];

   // Per-stage pairing tables are constants; only the stg-selected column is live.
   logic [IW-1:0]   lo_tab [NSTG_T][NU];
   logic [IW-1:0]   hi_tab [NSTG_T][NU];
   logic            up_tab [NSTG_T][NU];

   logic [IW-1:0]   pa    [NU];
   logic [IW-1:0]   pb    [NU];
   logic [W-1:0]    ce_lo [NU];
   logic [W-1:0]    ce_hi [NU];

   for (genvar s = 0; s < NSTG_T; s++) begin : g_stage
      for (genvar u = 0; u < NU; u++) begin : g_tab
         localparam int K = stage_k(s, N);
         localparam int J = stage_j(s, N);
         localparam int I = (u / J) * 2 * J + (u % J);
         assign lo_tab[s][u] = IW'(I);
         assign hi_tab[s][u] = IW'(I + J);
         assign up_tab[s][u] = ((I & K) == 0);
      end
   end

   for (genvar u = 0; u < NU; u++) begin : g_unit
      logic up;
      assign pa[u] = lo_tab[stg_q][u];
      assign pb[u] = hi_tab[stg_q][u];
      assign up    = up_tab[stg_q][u];

      cmp_exch #(.W(W)) u_ce (
         .a      (bank[pa[u]]),
         .b      (bank[pb[u]]),
         .up     (up),
         .lo_pos (ce_lo[u]),
         .hi_pos (ce_hi[u])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         idx_q   <= '0;
         stg_q   <= '0;
      end else begin
         state_q <= state_nxt;
         idx_q   <= idx_nxt;
         stg_q   <= stg_nxt;
      end
   end

   // Bank contents carry no reset value; they are always refilled by LOAD.
   always_ff @(posedge clk) begin
      if (load_en) begin
         bank[idx_q] <= in_data;
      end else if (sort_en) begin
         for (int u = 0; u < NU; u++) begin
            bank[pa[u]] <= ce_lo[u];
            bank[pb[u]] <= ce_hi[u];
         end
      end
   end

   always_comb begin
      state_nxt = state_q;
      idx_nxt   = idx_q;
      stg_nxt   = stg_q;
      load_en   = 1'b0;
      sort_en   = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      busy      = (state_q != LOAD);

      unique case (state_q)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_en = 1'b1;
               idx_nxt = idx_q + 1'b1;
               if (idx_q == IW'(N - 1)) begin
                  idx_nxt   = '0;
                  stg_nxt   = '0;
                  state_nxt = SORT;
               end
            end
         end
         SORT: begin
            sort_en = 1'b1;
            stg_nxt = stg_q + 1'b1;
            if (stg_q == SW'(NSTG_T - 1)) begin
               stg_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_data  = bank[idx_q];
            out_last  = (idx_q == IW'(N - 1));
            if (out_ready) begin
               idx_nxt = idx_q + 1'b1;
               if (idx_q == IW'(N - 1)) begin
                  idx_nxt   = '0;
                  state_nxt = LOAD;
               end
            end
         end
         default: state_nxt = LOAD;
      endcase

      // abort wins over every other transition, including a same-edge capture.
      if (abort) begin
         state_nxt = LOAD;
         idx_nxt   = '0;
         stg_nxt   = '0;
         load_en   = 1'b0;
         sort_en   = 1'b0;
      end
   end

endmodule

// File: tb/tb_sort_16x8b_bitonic_seq.sv
// Bench for the sequenced bitonic sorter: table vectors, random batches against
// a counting-sort reference, and abort / reset / idle-protocol sequences.
module tb_sort_16x8b_bitonic_seq;

   localparam int N    = 16;
   localparam int NSTG = 10;

   typedef logic [7:0] batch_t [N];

   typedef struct packed {
      logic [N-1:0][7:0] din;
      logic [N-1:0][7:0] dexp;
      logic [6:0]        rdy;
      logic [6:0]        gap;
   } vec_t;

   logic       clk, rst_n, abort, in_valid, in_ready, out_valid, out_ready, out_last, busy;
   logic [7:0] in_data, out_data;

   int errors = 0;
   int checks = 0;

   sort_16x8b_bitonic_seq #(.W(8), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: histogram of values, emitted in increasing value order.
   task automatic ref_sort(input batch_t d, output batch_t r);
      int hist [256];
      int k;
      foreach (hist[v]) hist[v] = 0;
      for (int i = 0; i < N; i++) hist[d[i]]++;
      k = 0;
      for (int v = 0; v < 256; v++)
         for (int c = 0; c < hist[v]; c++) begin
            r[k] = 8'(v);
            k++;
         end
   endtask

   task automatic rand_batch(output batch_t d);
      for (int i = 0; i < N; i++) d[i] = 8'($urandom);
   endtask

   task automatic load_batch(input batch_t d, input int gap_pct);
      int n;
      for (int i = 0; i < N; i++) begin
         while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = d[i];
         n = 0;
         while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (n >= 100) chk("load_ready_timeout", 0, 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_first_valid();
      int n;
      chk("sort_busy", busy, 1);
      chk("sort_in_ready", in_ready, 0);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("first_valid_edges", n, NSTG);
   endtask

   task automatic drain(input int rdy_pct, input int n_out, output batch_t got);
      int cnt, guard;
      logic [7:0] pd;
      logic pl;
      bit stalled;
      cnt = 0; guard = 0; stalled = 0; pd = '0; pl = 1'b0;
      for (int i = 0; i < N; i++) got[i] = '0;
      while (cnt < n_out && guard < 4000) begin
         chk("drain_valid", out_valid, 1);
         if (!out_valid) break;
         if (stalled) begin
            chk("stall_data", out_data, pd);
            chk("stall_last", out_last, pl);
         end
         chk("last_flag", out_last, (cnt == N - 1));
         out_ready = ($urandom_range(99) < rdy_pct);
         if (out_ready) begin
            got[cnt] = out_data;
            cnt++;
            stalled = 0;
         end else begin
            stalled = 1;
            pd = out_data;
            pl = out_last;
         end
         @(negedge clk);
         guard++;
      end
      if (guard >= 4000) chk("drain_timeout", 0, 1);
      out_ready = 1'b0;
   endtask

   task automatic cmp_batch(input string name, input batch_t got, input batch_t e, input int n);
      for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", name, i), got[i], e[i]);
   endtask

   task automatic run_batch(input string name, input batch_t d, input batch_t e,
                            input int gap, input int rdy);
      batch_t got;
      load_batch(d, gap);
      wait_first_valid();
      drain(rdy, N, got);
      cmp_batch(name, got, e, N);
      chk({name, "_done_busy"}, busy, 0);
      chk({name, "_done_in_ready"}, in_ready, 1);
   endtask

   batch_t dup_in  = '{8'd255, 8'd0, 8'd7, 8'd7, 8'd128, 8'd0, 8'd255, 8'd1,
                       8'd2, 8'd3, 8'd7, 8'd200, 8'd9, 8'd9, 8'd0, 8'd255};
   batch_t dup_exp = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd7,
                       8'd7, 8'd9, 8'd9, 8'd128, 8'd200, 8'd255, 8'd255, 8'd255};

   initial begin
      vec_t   tbl [5];
      batch_t din, dexp, got, desc, asc;

      rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < N; i++) begin
         desc[i] = 8'(N - 1 - i);
         asc[i]  = 8'(i);
         tbl[0].din[i] = 8'(N - 1 - i);  tbl[0].dexp[i] = 8'(i);
         tbl[1].din[i] = dup_in[i];      tbl[1].dexp[i] = dup_exp[i];
         tbl[2].din[i] = 8'(i * 17);     tbl[2].dexp[i] = 8'(i * 17);
         tbl[3].din[i] = 8'hAA;          tbl[3].dexp[i] = 8'hAA;
         tbl[4].din[i] = i[0] ? 8'd255 : 8'd0;
         tbl[4].dexp[i] = (i < N / 2) ? 8'd0 : 8'd255;
      end
      tbl[0].rdy = 7'd100; tbl[0].gap = 7'd0;
      tbl[1].rdy = 7'd100; tbl[1].gap = 7'd0;
      tbl[2].rdy = 7'd60;  tbl[2].gap = 7'd20;
      tbl[3].rdy = 7'd50;  tbl[3].gap = 7'd50;
      tbl[4].rdy = 7'd30;  tbl[4].gap = 7'd10;

      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < N; i++) begin
            din[i]  = tbl[t].din[i];
            dexp[i] = tbl[t].dexp[i];
         end
         run_batch($sformatf("vec%0d", t), din, dexp, int'(tbl[t].gap), int'(tbl[t].rdy));
      end

      // Random batches with input gaps and output backpressure.
      for (int b = 0; b < 100; b++) begin
         rand_batch(din);
         ref_sort(din, dexp);
         run_batch($sformatf("rnd%0d", b), din, dexp, 30, 50);
      end

      // Abort at the fifth SORT cycle.
      rand_batch(din);
      load_batch(din, 0);
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_sort_busy", busy, 0);
      chk("abort_sort_in_ready", in_ready, 1);
      chk("abort_sort_out_valid", out_valid, 0);
      run_batch("post_abort", desc, asc, 0, 100);

      // Abort mid-LOAD with an element offered on the same edge.
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_data = 8'd0;
      abort   = 1'b1;
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abort_load_busy", busy, 0);
      rand_batch(din);
      ref_sort(din, dexp);
      run_batch("post_abort_load", din, dexp, 10, 70);

      // Asynchronous reset after six outputs.
      rand_batch(din);
      ref_sort(din, dexp);
      load_batch(din, 0);
      wait_first_valid();
      drain(100, 6, got);
      cmp_batch("pre_reset", got, dexp, 6);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_busy", busy, 0);
      chk("arst_out_data", out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rand_batch(din);
      ref_sort(din, dexp);
      run_batch("post_reset", din, dexp, 20, 50);

      // in_valid held through SORT/DRAIN, out_ready toggled during LOAD.
      for (int i = 0; i < N; i++) begin
         in_valid  = 1'b1;
         in_data   = desc[i];
         out_ready = i[0];
         @(negedge clk);
      end
      out_ready = 1'b0;
      in_data   = 8'($urandom);
      wait_first_valid();
      drain(100, N, got);
      in_valid = 1'b0;
      cmp_batch("idle_proto", got, asc, N);
      chk("idle_done_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected done");
      $fatal(1, "timeout");
   end

endmodule
